// File: rtl/minbd_arb_pkg.sv
// Shared types and helpers for the rotating-priority arbiter.
// The grant-lock feature of the top is enabled by defining RR_ARB_LOCK_EN.
package minbd_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Index / pointer width; a single requester still needs a 1-bit index.
    function automatic int arb_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/rr_mask_sel.sv
// Combinational rotating-priority selector: requests below ptr win first,
// highest bit first; otherwise the highest requesting bit overall wins.
module rr_mask_sel
    import minbd_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = arb_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic [WIDTH-1:0] masked;
    logic             masked_hit;
    logic [IDX_W-1:0] masked_idx;
    logic [IDX_W-1:0] plain_idx;

    always_comb begin
        masked     = '0;
        masked_hit = 1'b0;
        masked_idx = '0;
        plain_idx  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            masked[i] = req[i] && (IDX_W'(i) < ptr);
        end
        // Ascending scan: the last set bit seen is the highest one.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (masked[i]) begin
                masked_hit = 1'b1;
                masked_idx = IDX_W'(i);
            end
            if (req[i]) begin
                plain_idx = IDX_W'(i);
            end
        end
        any_req    = |req;
        winner_idx = masked_hit ? masked_idx : plain_idx;
        winner     = any_req ? (WIDTH'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// Rotating-priority arbiter with registered one-hot grant and ack handshake.
// Define RR_ARB_LOCK_EN to add the lock port (grant held across ack for multi-flit).
module rr_prio_arbiter
    import minbd_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = arb_idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [WIDTH-1:0] gnt_n;
    logic [IDX_W-1:0] gnt_idx_n;
    logic [IDX_W-1:0] sel_ptr;
    logic [WIDTH-1:0] winner;
    logic [IDX_W-1:0] winner_idx;
    logic             any_req;
    logic             ack_ok;
    logic             lock_hold;

    assign ack_ok = (state == ARB_GRANT) && ack;

`ifdef RR_ARB_LOCK_EN
    // A locked ack only holds while the owner still requests; otherwise it releases.
    assign lock_hold = ack_ok && lock && req[gnt_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // On an accepted ack the new pointer feeds the selector in the same cycle.
    assign sel_ptr = (ack_ok && !lock_hold) ? gnt_idx : ptr;

    rr_mask_sel #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_sel (
        .req       (req),
        .ptr       (sel_ptr),
        .winner    (winner),
        .winner_idx(winner_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        gnt_idx_n = gnt_idx;
        unique case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_n   = ARB_GRANT;
                    gnt_n     = winner;
                    gnt_idx_n = winner_idx;
                end else begin
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                end
            end
            ARB_GRANT: begin
                if (lock_hold) begin
                    state_n = ARB_GRANT;
                end else if (ack) begin
                    ptr_n = gnt_idx;
                    if (any_req) begin
                        gnt_n     = winner;
                        gnt_idx_n = winner_idx;
                    end else begin
                        state_n   = ARB_IDLE;
                        gnt_n     = '0;
                        gnt_idx_n = '0;
                    end
                end else if (!req[gnt_idx]) begin
                    state_n   = ARB_IDLE;
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                end
            end
            default: begin
                state_n   = ARB_IDLE;
                gnt_n     = '0;
                gnt_idx_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            gnt_idx <= gnt_idx_n;
        end
    end

    assign gnt_valid = (state == ARB_GRANT);

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Self-checking bench for rr_prio_arbiter (WIDTH=4): directed scenarios plus
// randomized traffic against a priority-list reference model.
module tb_rr_prio_arbiter;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] req;
    logic             ack;
    logic             lock;
    logic [WIDTH-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    int tests;
    int fails;

    // Reference model: grant owner, validity and rotation pointer as integers.
    int  m_ptr;
    int  m_gi;
    bit  m_valid;

    rr_prio_arbiter #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
`ifdef RR_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk the priority list ptr-1, ptr-2, ... wrapping; first requester wins.
    function automatic int pick(input logic [WIDTH-1:0] r, input int p);
        for (int k = 1; k <= WIDTH; k++) begin
            int c;
            c = (p - k + WIDTH) % WIDTH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_gi    = 0;
        m_valid = 0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] r, input logic a, input logic l);
        bit lock_on;
        int w;
`ifdef RR_ARB_LOCK_EN
        lock_on = l;
`else
        lock_on = 0;
`endif
        if (!m_valid) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1;
                m_gi    = w;
            end
        end else if (a && lock_on && r[m_gi]) begin
            m_valid = 1;
        end else if (a) begin
            m_ptr = m_gi;
            w = pick(r, m_ptr);
            if (w >= 0) m_gi = w;
            else m_valid = 0;
        end else if (!r[m_gi]) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] eg;
        logic [IDX_W-1:0] ei;
        eg = m_valid ? (WIDTH'(1) << m_gi) : '0;
        ei = m_valid ? IDX_W'(m_gi) : '0;
        tests++;
        assert (gnt === eg) else begin
            fails++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
        end
        tests++;
        assert (gnt_valid === m_valid) else begin
            fails++;
            $error("FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, m_valid);
        end
        tests++;
        assert (gnt_idx === ei) else begin
            fails++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, ei);
        end
    endtask

    task automatic check_const(input string tag, input logic [WIDTH-1:0] eg,
                               input logic ev, input logic [IDX_W-1:0] ei);
        tests++;
        assert (gnt === eg && gnt_valid === ev && gnt_idx === ei) else begin
            fails++;
            $error("FAIL %s observed gnt=%b valid=%b idx=%0d expected gnt=%b valid=%b idx=%0d",
                   tag, gnt, gnt_valid, gnt_idx, eg, ev, ei);
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] r, input logic a, input logic l);
        req  = r;
        ack  = a;
        lock = l;
        @(posedge clk);
        model_step(r, a, l);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        lock  = 1'b0;
        model_reset();
        @(negedge clk);
        check_const("reset", 4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        lock  = 1'b0;
        model_reset();

        // 1/2: first grant at ptr=0, then ack rotates past requester 3.
        do_reset();
        step(4'b1010, 1'b0, 1'b0);
        check_const("t1_first_grant", 4'b1000, 1'b1, 2'd3);
        step(4'b1010, 1'b1, 1'b0);
        check_const("t2_after_ack", 4'b0010, 1'b1, 2'd1);
        check_model("t2_model");

        // 3: all requesting, ack every cycle -> strict rotation.
        do_reset();
        step(4'b1111, 1'b1, 1'b0);
        check_const("t3_g0", 4'b1000, 1'b1, 2'd3);
        step(4'b1111, 1'b1, 1'b0);
        check_const("t3_g1", 4'b0100, 1'b1, 2'd2);
        step(4'b1111, 1'b1, 1'b0);
        check_const("t3_g2", 4'b0010, 1'b1, 2'd1);
        step(4'b1111, 1'b1, 1'b0);
        check_const("t3_g3", 4'b0001, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 1'b0);
        check_const("t3_g4", 4'b1000, 1'b1, 2'd3);

        // 4: revoke without ack leaves ptr at 0.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        check_const("t4_grant", 4'b0100, 1'b1, 2'd2);
        step(4'b0000, 1'b0, 1'b0);
        check_const("t4_revoke", 4'b0000, 1'b0, 2'd0);
        step(4'b1100, 1'b0, 1'b0);
        check_const("t4_regrant", 4'b1000, 1'b1, 2'd3);

        // 5: asynchronous reset between edges, after a rotation moved ptr.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        check_const("t5_pre", 4'b0010, 1'b1, 2'd1);
        step(4'b0100, 1'b1, 1'b0);
        check_const("t5_gnt", 4'b0100, 1'b1, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check_const("t5_async", 4'b0000, 1'b0, 2'd0);
        model_reset();
        req = '0;
        ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0001, 1'b0, 1'b0);
        check_const("t5_after", 4'b0001, 1'b1, 2'd0);
        step(4'b1001, 1'b0, 1'b0);
        check_const("t5_ptr0", 4'b0001, 1'b1, 2'd0);

        // Ack while idle must be ignored.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check_const("idle_ack", 4'b0000, 1'b0, 2'd0);
        step(4'b0011, 1'b0, 1'b0);
        check_model("idle_ack_model");

`ifdef RR_ARB_LOCK_EN
        // 6: locked acks hold the grant; unlocked ack releases and rotates.
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b1, 1'b1);
            check_const("t6_locked", 4'b1000, 1'b1, 2'd3);
        end
        step(4'b1111, 1'b1, 1'b0);
        check_const("t6_release", 4'b0100, 1'b1, 2'd2);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [WIDTH-1:0] r;
            r = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model("random");
            tests++;
            assert ($countones(gnt) <= 1) else begin
                fails++;
                $error("FAIL onehot observed=%b expected=at most one bit", gnt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
